// File: rtl/tp_dbg_pkg.sv
// Shared encodings and constants for the bank-25 test-point debug path.
// Trigger state codes, word width and blanking length.
package tp_dbg_pkg;

  localparam int TP_WIDTH  = 16;
  localparam int BLANK_CYC = 2;

  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_ARMED  = 2'd1,
    TS_POST   = 2'd2,
    TS_FROZEN = 2'd3
  } trig_state_e;

  // Masked equality used by the trigger comparator.
  function automatic logic trig_hit(
    input logic [TP_WIDTH-1:0] samp,
    input logic [TP_WIDTH-1:0] mask,
    input logic [TP_WIDTH-1:0] val
  );
    return ((samp ^ val) & mask) == '0;
  endfunction

endpackage

// File: rtl/tp_pulse_stretch.sv
// Single-bit pulse stretcher: rising edge reloads a countdown so
// one-cycle strobes stay visible for STRETCH cycles on a scope.
module tp_pulse_stretch #(
  parameter int STRETCH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic samp_i,
  input  logic en_i,
  output logic out_o
);

  localparam logic [7:0] RELOAD = 8'(STRETCH - 1);

  logic       prev_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       rise;

  assign rise = samp_i & ~prev_q;

  // Reload on edge (retriggerable), count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = 8'd0;
    end else if (rise) begin
      cnt_d = RELOAD;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Edge history and counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      prev_q <= samp_i;
      cnt_q  <= cnt_d;
    end
  end

  assign out_o = en_i ? (samp_i | (cnt_q != 8'd0))
                      : samp_i;

endmodule

// File: rtl/tp_probe_capture.sv
// Probe group select, pulse stretch, blanking and one-shot freeze
// feeding the 16-bit test-point word.
import tp_dbg_pkg::*;

module tp_probe_capture #(
  parameter int NGRP     = 4,
  parameter int STRETCH  = 8,
  parameter int POST_DLY = 16
) (
  input  logic                 CLK,
  input  logic                 RST_B,
  input  logic [16*NGRP-1:0]   PROBE_IN,
  input  logic [2:0]           SEL,
  input  logic                 SEL_LD,
  input  logic [TP_WIDTH-1:0]  STRETCH_MASK,
  input  logic [TP_WIDTH-1:0]  TRIG_MASK,
  input  logic [TP_WIDTH-1:0]  TRIG_VAL,
  input  logic                 ARM,
  input  logic                 FREEZE_CLR,
  output logic [TP_WIDTH-1:0]  TP_OUT,
  output logic [1:0]           TRIG_STATE,
  output logic                 TRIGGERED
);

  trig_state_e         state_q;
  trig_state_e         state_d;
  logic [15:0]         post_q;
  logic [15:0]         post_d;
  logic                trig_q;
  logic                trig_d;
  logic [2:0]          sel_q;
  logic [2:0]          sel_d;
  logic [1:0]          blank_q;
  logic [1:0]          blank_d;
  logic [TP_WIDTH-1:0] grp;
  logic [TP_WIDTH-1:0] samp_q;
  logic [TP_WIDTH-1:0] str;
  logic [TP_WIDTH-1:0] tp_q;
  logic [TP_WIDTH-1:0] tp_d;
  logic                sel_acc;

  assign sel_acc = SEL_LD && (state_q == TS_IDLE);

  // Group select; out-of-range codes fall back to group 0.
  always_comb begin
    sel_d   = sel_q;
    blank_d = blank_q;
    if (sel_acc) begin
      sel_d   = (int'(SEL) < NGRP) ? SEL : 3'd0;
      blank_d = 2'(BLANK_CYC);
    end else if (blank_q != 2'd0) begin
      blank_d = blank_q - 2'd1;
    end
  end

  // Mux the selected probe group.
  always_comb begin
    grp = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (sel_q == 3'(g)) begin
        grp = PROBE_IN[16*g +: 16];
      end
    end
  end

  for (genvar i = 0; i < TP_WIDTH; i++) begin : g_str
    tp_pulse_stretch #(
      .STRETCH (STRETCH)
    ) u_str (
      .clk_i  (CLK),
      .rst_ni (RST_B),
      .samp_i (samp_q[i]),
      .en_i   (STRETCH_MASK[i]),
      .out_o  (str[i])
    );
  end

  // Output word: hold when frozen, zero while blanking.
  always_comb begin
    tp_d = str;
    if (state_q == TS_FROZEN) begin
      tp_d = tp_q;
    end else if (blank_q != 2'd0) begin
      tp_d = '0;
    end
  end

  // Trigger FSM; freeze lands POST_DLY edges after entering POST,
  // never sooner than one edge.
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    unique case (state_q)
      TS_IDLE: begin
        if (ARM) state_d = TS_ARMED;
      end
      TS_ARMED: begin
        if (trig_hit(samp_q, TRIG_MASK, TRIG_VAL)) begin
          state_d = TS_POST;
          post_d  = 16'(POST_DLY);
        end
      end
      TS_POST: begin
        if (post_q <= 16'd1) begin
          state_d = TS_FROZEN;
        end else begin
          post_d = post_q - 16'd1;
        end
      end
      TS_FROZEN: begin
        state_d = TS_FROZEN;
      end
      default: state_d = TS_IDLE;
    endcase
    if (FREEZE_CLR) state_d = TS_IDLE;
    trig_d = (state_d == TS_POST) ||
             (state_d == TS_FROZEN);
  end

  // Pipeline, select and trigger registers.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= TS_IDLE;
      post_q  <= 16'd0;
      trig_q  <= 1'b0;
      sel_q   <= 3'd0;
      blank_q <= 2'd0;
      samp_q  <= '0;
      tp_q    <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      samp_q  <= grp;
      tp_q    <= tp_d;
    end
  end

  assign TP_OUT     = tp_q;
  assign TRIG_STATE = state_q;
  assign TRIGGERED  = trig_q;

endmodule

// File: tb/tb_tp_probe_capture.sv
// Randomised and directed bench for tp_probe_capture with a
// timestamp-based reference model and a scoreboard queue.
module tb_tp_probe_capture;

  localparam int NGRP     = 4;
  localparam int STRETCH  = 8;
  localparam int POST_DLY = 3;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [63:0] probe;
  logic [2:0]  sel;
  logic        sel_ld;
  logic [15:0] smask;
  logic [15:0] tmask;
  logic [15:0] tval;
  logic        arm;
  logic        fclr;
  logic [15:0] tp_out;
  logic [1:0]  trig_state;
  logic        triggered;

  tp_probe_capture #(
    .NGRP     (NGRP),
    .STRETCH  (STRETCH),
    .POST_DLY (POST_DLY)
  ) dut (
    .CLK          (clk),
    .RST_B        (rst_b),
    .PROBE_IN     (probe),
    .SEL          (sel),
    .SEL_LD       (sel_ld),
    .STRETCH_MASK (smask),
    .TRIG_MASK    (tmask),
    .TRIG_VAL     (tval),
    .ARM          (arm),
    .FREEZE_CLR   (fclr),
    .TP_OUT       (tp_out),
    .TRIG_STATE   (trig_state),
    .TRIGGERED    (triggered)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tp;
    logic [1:0]  st;
    logic        trg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: edge counter plus event timestamps.
  int          m_edge;
  logic [15:0] m_samp;
  logic [15:0] m_tp;
  int          m_sel;
  int          m_load;
  int          m_state;
  int          m_frz;
  int          m_rise[16];
  int          m_unmask[16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  function automatic void model_reset();
    m_edge  = 0;
    m_samp  = 16'h0;
    m_tp    = 16'h0;
    m_sel   = 0;
    m_load  = -100;
    m_state = 0;
    m_frz   = 0;
    for (int i = 0; i < 16; i++) begin
      m_rise[i]   = -1000;
      m_unmask[i] = -1000;
    end
  endfunction

  // Predict outputs after the coming edge from current inputs.
  function automatic void model_edge();
    int          u;
    int          ns;
    logic [15:0] st;
    logic [15:0] nsamp;
    exp_t        e;
    u = m_edge;
    for (int i = 0; i < 16; i++)
      if (!smask[i]) m_unmask[i] = u;
    for (int i = 0; i < 16; i++) begin
      st[i] = m_samp[i];
      if (smask[i] && m_rise[i] > m_unmask[i] &&
          (u - m_rise[i]) < STRETCH)
        st[i] = 1'b1;
    end
    if (m_state != 3) begin
      if ((u + 1 - m_load) <= 2) m_tp = 16'h0;
      else m_tp = st;
    end
    nsamp = probe[m_sel*16 +: 16];
    ns = m_state;
    case (m_state)
      0: if (arm) ns = 1;
      1: if (((m_samp ^ tval) & tmask) == 16'h0) begin
        ns = 2;
        m_frz = u + 1 + ((POST_DLY < 1) ? 1 : POST_DLY);
      end
      2: if (u + 1 >= m_frz) ns = 3;
      default: ;
    endcase
    if (fclr) ns = 0;
    if (sel_ld && m_state == 0) begin
      m_sel  = (int'(sel) < NGRP) ? int'(sel) : 0;
      m_load = u + 1;
    end
    for (int i = 0; i < 16; i++)
      if (nsamp[i] && !m_samp[i]) m_rise[i] = u + 1;
    m_samp  = nsamp;
    m_state = ns;
    m_edge  = u + 1;
    e.tp  = m_tp;
    e.st  = 2'(ns);
    e.trg = (ns >= 2);
    exp_q.push_back(e);
  endfunction

  // Inputs are set at negedge+1; one call covers one edge.
  task automatic step();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic set_grp(input int g, input logic [15:0] v);
    probe[g*16 +: 16] = v;
  endtask

  // Monitor: compare whatever the DUT presents against the queue.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("tp_out", 32'(tp_out), 32'(mon_e.tp));
      chk("trig_state", 32'(trig_state), 32'(mon_e.st));
      chk("triggered", 32'(triggered), 32'(mon_e.trg));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_b  = 1'b0;
    probe  = 64'h0;
    sel    = 3'd0;
    sel_ld = 1'b0;
    smask  = 16'h0;
    tmask  = 16'hFFFF;
    tval   = 16'hFFFF;
    arm    = 1'b0;
    fclr   = 1'b0;
    model_reset();
    set_grp(0, 16'h1111);
    set_grp(1, 16'h2222);
    set_grp(2, 16'hA5C3);
    set_grp(3, 16'h4444);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tp", 32'(tp_out), 32'h0);
    chk("rst_state", 32'(trig_state), 32'h0);
    chk("rst_trig", 32'(triggered), 32'h0);
    rst_b = 1'b1;
    repeat (3) step();

    // Group select with blanking and 2-cycle latency.
    sel = 3'd2; sel_ld = 1'b1; step();
    sel_ld = 1'b0;
    repeat (4) step();
    chk("grp2_value", 32'(tp_out), 32'hA5C3);
    set_grp(2, 16'h5A3C);
    repeat (2) step();
    chk("latency2", 32'(tp_out), 32'h5A3C);

    // Stretch a single pulse on masked bit 0.
    smask = 16'h0001;
    set_grp(2, 16'h0);
    repeat (10) step();
    cnt = 0;
    set_grp(2, 16'h0001); step();
    cnt += int'(tp_out[0]);
    set_grp(2, 16'h0);
    for (int k = 0; k < 13; k++) begin
      step(); cnt += int'(tp_out[0]);
    end
    chk("stretch_len", 32'(cnt), 32'd8);

    // Retrigger five cycles after the first edge.
    cnt = 0;
    for (int k = 0; k < 22; k++) begin
      set_grp(2, (k == 0 || k == 5) ? 16'h1 : 16'h0);
      step(); cnt += int'(tp_out[0]);
    end
    chk("retrig_len", 32'(cnt), 32'd13);

    // Unmasked bit passes straight through.
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      set_grp(2, (k == 0) ? 16'h2 : 16'h0);
      step(); cnt += int'(tp_out[1]);
    end
    chk("unmasked_len", 32'(cnt), 32'd1);

    // Trigger, post delay and freeze.
    tmask = 16'h00FF; tval = 16'h0042;
    repeat (2) step();
    arm = 1'b1; step(); arm = 1'b0;
    set_grp(2, 16'h1242);
    repeat (5) step();
    chk("frozen_state", 32'(trig_state), 32'd3);
    chk("frozen_trig", 32'(triggered), 32'd1);
    for (int k = 0; k < 6; k++) begin
      set_grp(2, 16'($urandom));
      step();
    end
    arm = 1'b1; step(); arm = 1'b0;
    sel = 3'd1; sel_ld = 1'b1; step(); sel_ld = 1'b0;
    fclr = 1'b1; step(); fclr = 1'b0;
    chk("clr_state", 32'(trig_state), 32'd0);
    repeat (4) step();

    // SEL_LD ignored while armed.
    tmask = 16'hFFFF; tval = 16'h0;
    set_grp(2, 16'h00F0);
    arm = 1'b1; step(); arm = 1'b0;
    sel = 3'd3; sel_ld = 1'b1; step(); sel_ld = 1'b0;
    repeat (4) step();
    fclr = 1'b1; step(); fclr = 1'b0;

    // ARM together with FREEZE_CLR stays idle.
    arm = 1'b1; fclr = 1'b1; step();
    arm = 1'b0; fclr = 1'b0;
    chk("arm_clr_idle", 32'(trig_state), 32'd0);

    // Out-of-range select maps to group 0.
    sel = 3'd6; sel_ld = 1'b1; step(); sel_ld = 1'b0;
    repeat (4) step();
    chk("sel6_grp0", 32'(tp_out), 32'h1111);

    // Zero trigger mask fires on the first armed cycle.
    tmask = 16'h0;
    arm = 1'b1; step(); arm = 1'b0;
    step();
    chk("mask0_post", 32'(trig_state), 32'd2);

    // Asynchronous reset while in POST.
    #2;
    rst_b = 1'b0;
    #1;
    chk("async_tp", 32'(tp_out), 32'h0);
    chk("async_state", 32'(trig_state), 32'h0);
    chk("async_trig", 32'(triggered), 32'h0);
    @(negedge clk);
    #1;
    exp_q.delete();
    model_reset();
    rst_b = 1'b1;

    // Randomised traffic against the model.
    for (int k = 0; k < 500; k++) begin
      probe  = {$urandom, $urandom} & {$urandom, $urandom};
      sel    = 3'($urandom_range(0, 7));
      sel_ld = ($urandom_range(0, 9) == 0);
      arm    = ($urandom_range(0, 7) == 0);
      fclr   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0)
        smask = 16'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        tmask = 16'($urandom & $urandom & $urandom);
        tval  = 16'($urandom);
      end
      step();
    end
    sel_ld = 1'b0; arm = 1'b0; fclr = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
